// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, reads instruction memory over
// a req/ack handshake and queues {instr, pc+4} for the IF/ID boundary.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t        state, state_n;
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic          req_n;
    logic [31:0]   addr_n;
    logic [63:0]   q_mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_n;
    logic          push, pop, flush, space;
    logic [31:0]   target, next_addr;

    assign target      = branch_addr & ~32'd3;
    assign next_addr   = imem_addr + 32'd4;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? q_mem[rd_ptr][63:32] : 32'd0;
    assign pc_out      = instr_valid ? q_mem[rd_ptr][31:0]  : 32'd0;

    // A new request is only issued when its returning word is guaranteed a slot.
    always_comb begin
        flush   = branch_taken;
        push    = (state == BUSY) && imem_ack && !branch_taken;
        pop     = instr_valid && !freeze && !branch_taken;
        count_n = flush ? '0 : count + CW'(push) - CW'(pop);
        space   = count_n < DEPTH_C;
    end

    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        req_n      = imem_req;
        addr_n     = imem_addr;
        case (state)
            IDLE: begin
                if (branch_taken) begin
                    fetch_pc_n = target;
                end else if (space) begin
                    req_n   = 1'b1;
                    addr_n  = fetch_pc;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        fetch_pc_n = target;
                        req_n      = 1'b0;
                        state_n    = IDLE;
                    end else begin
                        fetch_pc_n = next_addr;
                        if (space) begin
                            addr_n = next_addr;
                        end else begin
                            req_n   = 1'b0;
                            state_n = IDLE;
                        end
                    end
                end else if (branch_taken) begin
                    // Request in flight cannot be withdrawn; its data is dropped in DRAIN.
                    fetch_pc_n = target;
                    state_n    = DRAIN;
                end
            end
            DRAIN: begin
                if (branch_taken) fetch_pc_n = target;
                if (imem_ack) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                req_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= 32'd0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
            count     <= count_n;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr] <= {imem_rdata, next_addr};
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios push expected words and
// acked addresses; monitors pop and compare as the DUT presents them.
module tb_fetch_unit;

    localparam logic [31:0] X = 32'hA5A5_0000;

    logic        clk = 0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          ack_cnt = 0;
    int          ack_limit = 0;
    int          wait_cnt = 0;
    logic [31:0] delay_addr = 32'h1;
    int          delay_n = 0;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic expect_word(input logic [31:0] a);
        exp_q.push_back({a ^ X, a + 32'd4});
    endtask

    // Memory model: acks within the granted budget, optionally stalling one address.
    initial begin
        imem_ack = 0;
        imem_rdata = 0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 0;
            if (rst && imem_req) begin
                if (imem_addr == delay_addr && wait_cnt < delay_n) begin
                    wait_cnt++;
                end else if (ack_cnt < ack_limit) begin
                    imem_ack = 1;
                    imem_rdata = imem_addr ^ X;
                    ack_cnt++;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (imem_req && imem_ack) begin
                    if (addr_q.size() == 0) fail_now("ack_addr_unexpected");
                    else check("ack_addr", imem_addr, addr_q.pop_front());
                end
                if (instr_valid && !freeze && !branch_taken) begin
                    if (exp_q.size() == 0) begin
                        fail_now("instr_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("instr", instr, e.word);
                        check("pc_out", pc_out, e.pc);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 0;
        freeze = 0;
        branch_taken = 0;
        branch_addr = 0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && addr_q.size() == 0) break;
            @(posedge clk);
        end
        #2;
        check({name, "_exp_left"}, exp_q.size(), 0);
        check({name, "_addr_left"}, addr_q.size(), 0);
    endtask

    task automatic wait_addr(input logic [31:0] a);
        logic found;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #2;
            if (imem_req && imem_addr == a) found = 1;
        end
        check("wait_addr_seen", {31'd0, found}, 32'd1);
    endtask

    initial begin
        rst = 0;
        freeze = 0;
        branch_taken = 0;
        branch_addr = 0;
        #12;
        check("rst_req", {31'd0, imem_req}, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", {31'd0, instr_valid}, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", pc_out, 0);

        // Streaming, zero-wait ack: one instruction per cycle.
        do_reset();
        ack_limit = ack_cnt + 8;
        for (int i = 0; i < 8; i++) begin
            expect_word(32'(i * 4));
            addr_q.push_back(32'(i * 4));
        end
        release_reset();
        @(posedge clk); #3;
        check("t1_first_req", {31'd0, imem_req}, 1);
        check("t1_first_addr", imem_addr, 0);
        check("t1_valid_c1", {31'd0, instr_valid}, 0);
        @(posedge clk); #3;
        check("t1_valid_c2", {31'd0, instr_valid}, 1);
        check("t1_head_instr", instr, X);
        check("t1_head_pc", pc_out, 4);
        repeat (7) @(posedge clk);
        @(negedge clk); #1;
        check("t1_throughput", exp_q.size(), 0);
        wait_drain("t1");

        // Freeze fills the queue, then release drains it and fetching resumes.
        do_reset();
        freeze = 1;
        ack_limit = ack_cnt + 6;
        for (int i = 0; i < 6; i++) begin
            expect_word(32'(i * 4));
            addr_q.push_back(32'(i * 4));
        end
        begin
            int base;
            base = ack_cnt;
            release_reset();
            repeat (10) @(posedge clk); #3;
            check("t2_full_req", {31'd0, imem_req}, 0);
            check("t2_full_acks", ack_cnt - base, 4);
        end
        check("t2_head_instr", instr, X);
        check("t2_head_pc", pc_out, 4);
        freeze = 0;
        repeat (4) @(posedge clk); #2;
        check("t2_pops", exp_q.size(), 2);
        wait_drain("t2");

        // Branch while a delayed ack is outstanding: that word is dropped.
        do_reset();
        ack_limit = ack_cnt + 5;
        wait_cnt = 0;
        delay_addr = 32'h8;
        delay_n = 3;
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h100);
        expect_word(32'h104);
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h4);
        addr_q.push_back(32'h8);
        addr_q.push_back(32'h100);
        addr_q.push_back(32'h104);
        release_reset();
        wait_addr(32'h8);
        @(posedge clk); #2;
        branch_taken = 1;
        branch_addr = 32'h103;
        @(posedge clk); #2;
        branch_taken = 0;
        #1;
        check("t3_drain_req", {31'd0, imem_req}, 1);
        check("t3_drain_addr", imem_addr, 32'h8);
        check("t3_drain_valid", {31'd0, instr_valid}, 0);
        wait_drain("t3");
        delay_addr = 32'h1;

        // Branch coinciding with the ack for 12.
        do_reset();
        ack_limit = ack_cnt + 6;
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h200);
        expect_word(32'h204);
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h4);
        addr_q.push_back(32'h8);
        addr_q.push_back(32'hC);
        addr_q.push_back(32'h200);
        addr_q.push_back(32'h204);
        release_reset();
        wait_addr(32'hC);
        branch_taken = 1;
        branch_addr = 32'h200;
        @(posedge clk); #2;
        branch_taken = 0;
        #1;
        check("t4_flush_valid", {31'd0, instr_valid}, 0);
        check("t4_idle_req", {31'd0, imem_req}, 0);
        wait_drain("t4");

        // PC wrap at the top of the address space.
        do_reset();
        branch_taken = 1;
        branch_addr = 32'hFFFF_FFF8;
        ack_limit = ack_cnt + 3;
        expect_word(32'hFFFF_FFF8);
        expect_word(32'hFFFF_FFFC);
        expect_word(32'h0);
        addr_q.push_back(32'hFFFF_FFF8);
        addr_q.push_back(32'hFFFF_FFFC);
        addr_q.push_back(32'h0);
        release_reset();
        @(posedge clk); #2;
        branch_taken = 0;
        check("t5_no_req_on_branch", {31'd0, imem_req}, 0);
        wait_drain("t5");

        // Asynchronous reset with two entries queued and a request in flight.
        do_reset();
        freeze = 1;
        ack_limit = ack_cnt + 2;
        addr_q.push_back(32'h0);
        addr_q.push_back(32'h4);
        release_reset();
        wait_addr(32'h8);
        check("t6_pre_valid", {31'd0, instr_valid}, 1);
        check("t6_pre_instr", instr, X);
        #1;
        rst = 0;
        #1;
        check("t6_rst_req", {31'd0, imem_req}, 0);
        check("t6_rst_valid", {31'd0, instr_valid}, 0);
        check("t6_rst_instr", instr, 0);
        check("t6_rst_pc", pc_out, 0);
        @(negedge clk);
        freeze = 0;
        check("t6_addr_left", addr_q.size(), 0);
        ack_limit = ack_cnt + 1;
        expect_word(32'h0);
        addr_q.push_back(32'h0);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #3;
        check("t6_restart_req", {31'd0, imem_req}, 1);
        check("t6_restart_addr", imem_addr, 0);
        wait_drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end that produces the decoded-stage instruction stream: owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch queue and presents {instr, PC+4} to the IF/ID boundary with a valid flag.
- Honours the decode-side freeze, and redirects on the branch_taken/branch_addr pair produced by the execute stage.

Parameters:
- DEPTH, 4, prefetch queue entries; power of 2, at least 2.
- RESET_PC, 32'h0000_0000, fetch address after reset; word aligned.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; state clears while rst==0.
- freeze  input  1  decode stall; head entry is held.
- branch_taken  input  1  one-cycle redirect request from execute.
- branch_addr  input  32  redirect target; bits [1:0] ignored (forced to 0).
- imem_req  output  1  registered read request.
- imem_addr  output  32  registered read address; stable while imem_req==1 and no ack yet.
- imem_ack  input  1  read complete; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  read data.
- instr_valid  output  1  queue not empty.
- instr  output  32  head instruction word.
- pc_out  output  32  head fetch address + 4.

Behaviour:
- Reset (rst==0): state=IDLE, fetch_pc=RESET_PC, queue empty (count=0, pointers 0).
- Reset outputs: imem_req=0, imem_addr=0, instr_valid=0, instr=0, pc_out=0.
- instr and pc_out read 0 whenever the queue is empty.
- Queue:
  - Circular FIFO of {word, addr+4}. Pop when instr_valid && !freeze && !branch_taken.
  - Push happens only on an accepted ack (see below).
  - Push and pop in the same cycle are legal; count is unchanged.
- Space rule:
  - A request may be issued only if (count_next + outstanding) < DEPTH.
  - Consequence: an ack never overflows the queue, and no request is issued while the queue is full.
- At most one outstanding request.
- State machine IDLE / BUSY / DRAIN:
  - IDLE, branch_taken: fetch_pc<=branch_addr&~3; stay IDLE; no request this cycle.
  - IDLE, space available, no branch: next cycle imem_req=1, imem_addr=fetch_pc; go to BUSY.
  - IDLE, otherwise: stay IDLE with imem_req=0.
  - BUSY, ack and no branch: push {imem_rdata, imem_addr+4}; fetch_pc<=imem_addr+4.
    - If space remains: stay BUSY and issue the next address back-to-back (imem_req stays 1).
    - Otherwise: go to IDLE with imem_req=0.
  - BUSY, ack and branch_taken in the same cycle: discard the data; flush the queue; fetch_pc<=branch_addr&~3; go to IDLE with imem_req=0.
  - BUSY, branch_taken and no ack: the request cannot be withdrawn. Keep imem_req and imem_addr stable; flush the queue; fetch_pc<=branch_addr&~3; go to DRAIN.
  - DRAIN, ack: discard imem_rdata; go to IDLE with imem_req=0.
  - DRAIN, further branch_taken: update fetch_pc to the new target; stay DRAIN.
- Flush on branch_taken: count=0 and pointers reset; instr_valid=0 in the following cycle.
- branch_taken has priority over freeze and over pop.
- Arithmetic: PC increments are modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Latency:
  - First imem_req=1 in the cycle after the first rising edge with rst==1.
  - instr_valid rises in the cycle after the accepted ack.
  - Steady-state throughput is 1 instruction/cycle with zero-wait ack.
- freeze alone never stops in-flight requests; fetching continues until the queue is full.
- Reset asserted mid-request: everything clears immediately, including imem_req.
- An ack arriving while imem_req==0 is ignored.

Test Plan:
- Reset, then hold imem_ack=1 with rdata=addr^32'hA5A5_0000 and no freeze -> imem_addr sequence 0,4,8,…; instr_valid from cycle 3; pc_out 4,8,12,… one per cycle.
- freeze=1 from the start with DEPTH=4 -> exactly 4 acks are accepted, then imem_req=0; head stays {word@0, pc_out=4}. Release freeze -> 4 pops on consecutive cycles and fetching resumes at addr 16.
- Ack delayed 3 cycles at addr 8; pulse branch_taken with branch_addr=32'h103 during the wait -> imem_addr holds 8 until ack; that word is dropped; next request is to 32'h100; queue empty meanwhile.
- branch_taken in the same cycle as ack for addr 12, branch_addr=32'h200 -> word 12 never appears on instr; next imem_addr=32'h200.
- Set fetch_pc near the top via branch_addr=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0; pc_out for FFFF_FFFC reads 0.
- Drive rst=0 asynchronously between edges while BUSY with 2 entries queued -> imem_req, instr_valid, instr, pc_out go to 0 immediately; after release, fetch restarts at RESET_PC.
